// File: rtl/sd_spi_pkg.sv
// Shared types for the SD SPI command engine: FSM states, error codes, CRC7 polynomial.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PRE,
        S_SEND,
        S_WAIT,
        S_READ,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BADLEN  = 2'b10;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 (init 0), one bit per enabled cycle; crc is valid the cycle after the last bit.
// No backpressure; clear has priority over bitEn.
module sd_crc7_serial (
    input  logic       cpuClock,
    input  logic       reset,
    input  logic       clear,
    input  logic       bitEn,
    input  logic       bitIn,
    output logic [6:0] crc
);
    import sd_spi_pkg::*;

    logic fb;
    assign fb = bitIn ^ crc[6];

    always_ff @(posedge cpuClock) begin
        if (reset || clear)
            crc <= '0;
        else if (bitEn)
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD SPI command engine: one command per cmdValid/cmdReady handshake, 48-bit frame out, 1..RESP_MAX_BYTES response in.
// cmdReady only in IDLE; done pulses once per accepted command; commands offered while busy are ignored.
module sd_spi_cmd_engine #(
    parameter int CLK_DIV        = 128,
    parameter int RESP_MAX_BYTES = 5,
    parameter int NCR_MAX        = 8,
    parameter int PRE_CLKS       = 8,
    parameter int POST_CLKS      = 8,
    localparam int RB            = $clog2(RESP_MAX_BYTES + 1)
) (
    input  logic                        cpuClock,
    input  logic                        reset,
    input  logic                        cmdValid,
    output logic                        cmdReady,
    input  logic [5:0]                  cmdIndex,
    input  logic [31:0]                 cmdArgument,
    input  logic [RB-1:0]               respBytes,
    output logic                        done,
    output logic [1:0]                  errorType,
    output logic [8*RESP_MAX_BYTES-1:0] respData,
    input  logic                        SD_MISO,
    output logic                        SD_SCLK,
    output logic                        SD_MOSI,
    output logic                        SD_CS
);
    import sd_spi_pkg::*;

    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW     = (NCR_MAX * 8 > 1) ? $clog2(NCR_MAX * 8) : 1;
    localparam int MAXC   = (PRE_CLKS > POST_CLKS) ? PRE_CLKS : POST_CLKS;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int RESP_W = 8 * RESP_MAX_BYTES;

    localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0]   POLL_LAST = PW'(NCR_MAX * 8 - 1);
    localparam logic [CW-1:0]   PRE_LAST  = CW'(PRE_CLKS - 1);
    localparam logic [CW-1:0]   POST_LAST = CW'(POST_CLKS);
    localparam logic [RB-1:0]   RB_MAX    = RB'(RESP_MAX_BYTES);
    localparam logic [RB+2:0]   RCNT_ONE  = 1;

    state_t              state, state_nxt;
    logic [DW-1:0]       div_cnt;
    logic                sclk_q, cs_q, mosi_q;
    logic [CW-1:0]       clk_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          crc_cnt;
    logic [PW-1:0]       poll_cnt;
    logic [RB+2:0]       resp_cnt;
    logic [39:0]         hdr_q;
    logic [RB-1:0]       rb_q;
    logic [1:0]          err_q;
    logic [RESP_W-1:0]   resp_sr;
    logic [6:0]          crc;
    logic [47:0]         frame_w;
    logic                sclk_on, tick, rise, fall, accept, len_bad, read_last, crc_en;

    assign accept    = (state == S_IDLE) && cmdValid;
    assign sclk_on   = (state == S_PRE) || (state == S_SEND) || (state == S_WAIT) ||
                       (state == S_READ) || (state == S_POST);
    assign tick      = sclk_on && (div_cnt == DIV_LAST);
    assign rise      = tick && !sclk_q;
    assign fall      = tick && sclk_q;
    assign len_bad   = (rb_q == '0) || (rb_q > RB_MAX);
    assign read_last = (resp_cnt == ({rb_q, 3'b000} - RCNT_ONE));
    assign crc_en    = (state != S_IDLE) && (crc_cnt != 6'd40);
    assign frame_w   = {hdr_q, crc, 1'b1};

    assign cmdReady = (state == S_IDLE);
    assign done     = (state == S_DONE);
    assign SD_SCLK  = sclk_q;
    assign SD_MOSI  = mosi_q;
    assign SD_CS    = cs_q;

    // CRC runs on from PRE into SEND if PRE is short; it is first needed at frame bit 40
    sd_crc7_serial u_crc (
        .cpuClock (cpuClock),
        .reset    (reset),
        .clear    (accept),
        .bitEn    (crc_en),
        .bitIn    (hdr_q[6'd39 - crc_cnt]),
        .crc      (crc)
    );

    always_ff @(posedge cpuClock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmdValid) state_nxt = S_CHECK;
            S_CHECK: state_nxt = len_bad ? S_DONE : S_PRE;
            S_PRE:   if (fall && clk_cnt == PRE_LAST) state_nxt = S_SEND;
            S_SEND:  if (fall && bit_cnt == 6'd47) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rise) begin
                    if (!SD_MISO)                    state_nxt = S_READ;
                    else if (poll_cnt == POLL_LAST) state_nxt = S_POST;
                end
            end
            S_READ:  if (rise && read_last) state_nxt = S_POST;
            S_POST:  if (fall && clk_cnt == POST_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cpuClock) begin
        if (reset) begin
            div_cnt   <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            crc_cnt   <= '0;
            poll_cnt  <= '0;
            resp_cnt  <= '0;
            hdr_q     <= '0;
            rb_q      <= '0;
            err_q     <= ERR_OK;
            resp_sr   <= '0;
            errorType <= ERR_OK;
            respData  <= '0;
        end else begin
            div_cnt <= (sclk_on && !tick) ? div_cnt + DW'(1) : '0;
            if (tick)
                sclk_q <= ~sclk_q;
            if (state == S_IDLE)
                crc_cnt <= '0;
            else if (crc_en)
                crc_cnt <= crc_cnt + 6'd1;

            case (state)
                S_IDLE: begin
                    if (cmdValid) begin
                        hdr_q    <= {2'b01, cmdIndex, cmdArgument};
                        rb_q     <= respBytes;
                        err_q    <= ERR_OK;
                        resp_sr  <= '0;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        poll_cnt <= '0;
                        resp_cnt <= '0;
                    end
                end
                S_CHECK: begin
                    if (len_bad) begin
                        errorType <= ERR_BADLEN;
                        respData  <= '0;
                    end
                end
                S_PRE: begin
                    if (fall) begin
                        if (clk_cnt == PRE_LAST) begin
                            clk_cnt <= '0;
                            cs_q    <= 1'b0;
                            mosi_q  <= frame_w[47];
                        end else begin
                            clk_cnt <= clk_cnt + CW'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (fall) begin
                        if (bit_cnt == 6'd47) begin
                            mosi_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            mosi_q  <= frame_w[6'd46 - bit_cnt];
                        end
                    end
                end
                S_WAIT: begin
                    // the start bit is a 0 already sitting in the zeroed shift register
                    if (rise) begin
                        if (!SD_MISO)
                            resp_cnt <= RCNT_ONE;
                        else if (poll_cnt == POLL_LAST)
                            err_q <= ERR_TIMEOUT;
                        else
                            poll_cnt <= poll_cnt + PW'(1);
                    end
                end
                S_READ: begin
                    if (rise) begin
                        resp_sr  <= {resp_sr[RESP_W-2:0], SD_MISO};
                        resp_cnt <= resp_cnt + RCNT_ONE;
                    end
                end
                S_POST: begin
                    // the first fall closes the last response clock, then CS goes high
                    if (fall) begin
                        cs_q    <= 1'b1;
                        clk_cnt <= clk_cnt + CW'(1);
                        if (clk_cnt == POST_LAST) begin
                            errorType <= err_q;
                            respData  <= resp_sr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine at CLK_DIV=4 with a behavioural SPI card model.
module tb_sd_spi_cmd_engine;

    logic        cpuClock = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [5:0]  cmdIndex = '0;
    logic [31:0] cmdArgument = '0;
    logic [2:0]  respBytes = '0;
    logic        done;
    logic [1:0]  errorType;
    logic [39:0] respData;
    logic        miso = 1'b1;
    logic        SD_SCLK, SD_MOSI, SD_CS;

    logic [127:0] tx_bits = '0;
    int           tx_len = 0;
    int           checks = 0;
    int           errors = 0;

    sd_spi_cmd_engine #(
        .CLK_DIV(4), .RESP_MAX_BYTES(5), .NCR_MAX(8), .PRE_CLKS(8), .POST_CLKS(8)
    ) dut (
        .cpuClock    (cpuClock),
        .reset       (reset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdIndex    (cmdIndex),
        .cmdArgument (cmdArgument),
        .respBytes   (respBytes),
        .done        (done),
        .errorType   (errorType),
        .respData    (respData),
        .SD_MISO     (miso),
        .SD_SCLK     (SD_SCLK),
        .SD_MOSI     (SD_MOSI),
        .SD_CS       (SD_CS)
    );

    always #5 cpuClock = ~cpuClock;

    // Card model: captures the frame on SCLK rises, then plays tx_bits back on falls
    logic        sclk_d = 1'b0;
    logic [47:0] rx_frame = '0;
    int rx_cnt = 0, tx_idx = 0, rise_cnt = 0, cs_low_cnt = 0, done_cnt = 0;
    int cyc = 0, last_rise = 0, rise_period = 0;

    always @(posedge cpuClock) begin
        cyc    <= cyc + 1;
        sclk_d <= SD_SCLK;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (SD_SCLK === 1'b1 && sclk_d === 1'b0) begin
            rise_cnt    <= rise_cnt + 1;
            rise_period <= cyc - last_rise;
            last_rise   <= cyc;
        end
        if (SD_CS === 1'b0) begin
            cs_low_cnt <= cs_low_cnt + 1;
            if (SD_SCLK === 1'b1 && sclk_d === 1'b0 && rx_cnt < 48) begin
                rx_frame <= {rx_frame[46:0], SD_MOSI};
                rx_cnt   <= rx_cnt + 1;
            end
            if (SD_SCLK === 1'b0 && sclk_d === 1'b1 && rx_cnt == 48) begin
                if (tx_idx < tx_len) miso <= tx_bits[tx_len - 1 - tx_idx];
                else                 miso <= 1'b1;
                tx_idx <= tx_idx + 1;
            end
        end else begin
            rx_cnt <= 0;
            tx_idx <= 0;
            miso   <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (cmdReady !== 1'b1 && guard < 3000) begin
            @(posedge cpuClock); #1;
            guard++;
        end
    endtask

    // Edges from the accepting edge until done is seen; inputs are scrambled after accept
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [2:0] rb, output int edges);
        wait_ready();
        cmdIndex = idx; cmdArgument = arg; respBytes = rb; cmdValid = 1'b1;
        @(posedge cpuClock); #1;
        cmdValid = 1'b0; cmdIndex = 6'h3F; cmdArgument = 32'hFFFF_FFFF; respBytes = 3'd7;
        edges = 0;
        while (done !== 1'b1 && edges < 5000) begin
            @(posedge cpuClock); #1;
            edges++;
        end
    endtask

    initial begin
        int e, r0, c0, d0, guard;

        repeat (3) @(posedge cpuClock);
        #1;
        check("rst_cmdReady", cmdReady, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_errorType", errorType, 2'b00);
        check("rst_respData", respData, 40'h0);
        check("rst_sclk", SD_SCLK, 1'b0);
        check("rst_mosi", SD_MOSI, 1'b1);
        check("rst_cs", SD_CS, 1'b1);
        reset = 1'b0;
        @(posedge cpuClock); #1;

        // CMD0, card: FF FF 01
        tx_bits = 128'hFFFF01; tx_len = 24;
        r0 = rise_cnt;
        run_cmd(6'd0, 32'h0, 3'd1, e);
        check("cmd0_edges", e, 705);
        check("cmd0_frame", rx_frame, 48'h40_0000_0000_95);
        check("cmd0_respData", respData, 40'h01);
        check("cmd0_err", errorType, 2'b00);
        check("cmd0_rises", rise_cnt - r0, 88);
        check("sclk_period", rise_period, 8);
        @(posedge cpuClock); #1;
        check("cmd0_done_pulse", done, 1'b0);
        check("cmd0_ready_after", cmdReady, 1'b1);

        // CMD8, card: FF 01 00 00 01 AA
        tx_bits = 128'hFF_01_00_00_01_AA; tx_len = 48;
        r0 = rise_cnt;
        run_cmd(6'd8, 32'h0000_01AA, 3'd5, e);
        check("cmd8_edges", e, 897);
        check("cmd8_frame", rx_frame, 48'h48_0000_01AA_87);
        check("cmd8_respData", respData, 40'h01_0000_01AA);
        check("cmd8_err", errorType, 2'b00);
        check("cmd8_rises", rise_cnt - r0, 112);

        // Timeout: MISO stays high
        tx_len = 0;
        r0 = rise_cnt;
        run_cmd(6'd0, 32'h0, 3'd1, e);
        check("tmo_edges", e, 1025);
        check("tmo_err", errorType, 2'b01);
        check("tmo_respData", respData, 40'h0);
        check("tmo_rises", rise_cnt - r0, 128);
        check("tmo_cs_high", SD_CS, 1'b1);

        // Bad lengths 0 and 6
        r0 = rise_cnt; c0 = cs_low_cnt;
        run_cmd(6'd17, 32'h1234_5678, 3'd0, e);
        check("bad0_edges", e, 1);
        check("bad0_err", errorType, 2'b10);
        check("bad0_rises", rise_cnt - r0, 0);
        check("bad0_cs", cs_low_cnt - c0, 0);
        r0 = rise_cnt; c0 = cs_low_cnt;
        run_cmd(6'd17, 32'h1234_5678, 3'd6, e);
        check("bad6_edges", e, 1);
        check("bad6_err", errorType, 2'b10);
        check("bad6_respData", respData, 40'h0);
        check("bad6_rises", rise_cnt - r0, 0);
        check("bad6_cs", cs_low_cnt - c0, 0);

        // Reset in the middle of SEND
        tx_bits = 128'hFFFF01; tx_len = 24;
        wait_ready();
        cmdIndex = 6'd0; cmdArgument = 32'h0; respBytes = 3'd1; cmdValid = 1'b1;
        @(posedge cpuClock); #1;
        cmdValid = 1'b0;
        guard = 0;
        while (rx_cnt < 20 && guard < 2000) begin
            @(posedge cpuClock); #1;
            guard++;
        end
        check("rstmid_reached_bit20", (rx_cnt >= 20), 1'b1);
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge cpuClock); #1;
        check("rstmid_cs", SD_CS, 1'b1);
        check("rstmid_sclk", SD_SCLK, 1'b0);
        check("rstmid_mosi", SD_MOSI, 1'b1);
        check("rstmid_ready", cmdReady, 1'b1);
        reset = 1'b0;
        repeat (40) @(posedge cpuClock);
        #1;
        check("rstmid_no_done", done_cnt - d0, 0);
        run_cmd(6'd0, 32'h0, 3'd1, e);
        check("after_rst_edges", e, 705);
        check("after_rst_frame", rx_frame, 48'h40_0000_0000_95);
        check("after_rst_respData", respData, 40'h01);
        check("after_rst_err", errorType, 2'b00);

        // cmdValid held through DONE: the next command is taken the cycle after
        wait_ready();
        d0 = done_cnt;
        respBytes = 3'd0; cmdValid = 1'b1;
        @(posedge cpuClock); #1;
        @(posedge cpuClock); #1;
        check("b2b_done1", done, 1'b1);
        check("b2b_ready_in_done", cmdReady, 1'b0);
        @(posedge cpuClock); #1;
        check("b2b_idle_ready", cmdReady, 1'b1);
        @(posedge cpuClock); #1;
        check("b2b_accepted", cmdReady, 1'b0);
        check("b2b_done_gap", done, 1'b0);
        @(posedge cpuClock); #1;
        check("b2b_done2", done, 1'b1);
        cmdValid = 1'b0;
        @(posedge cpuClock); #1;
        check("b2b_done_count", done_cnt - d0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
